// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte to the keyboard over open-drain PS2_CLK/PS2_DAT:
//   clock inhibit -> request-to-send (start bit) -> 10 device-clocked bits
//   (d0..d7, odd parity, stop) -> device ACK bit -> wait for bus idle.
// Ports:
//   clk, reset            CLOCK_50 domain, synchronous active-high reset
//   tx_data, tx_valid     byte and request; accepted when tx_valid && tx_ready
//   tx_ready              high only in IDLE
//   busy                  high in every state except IDLE
//   done / error          one-cycle pulses: device ACK / NACK or timeout
//   ps2_clk_async         raw PS2_CLK pin level
//   ps2_data_async        raw PS2_DAT pin level
//   ps2_clk_oe            1 = pull PS2_CLK low, 0 = release
//   ps2_data_oe           1 = pull PS2_DAT low, 0 = release
// Optional macro PS2_TX_RESEND_EN: retry a failed frame up to MAX_RETRIES
// times before pulsing error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int WW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, FAIL
  } state_t;

  state_t          state;
  logic            clk_s1, clk_s2, clk_prev;
  logic            data_s1, data_s2;
  logic            fe;
  logic [9:0]      shift;
  logic [3:0]      bit_idx;
  logic [PW-1:0]   cnt;
  logic [WW-1:0]   wdog;
  logic            last_try;

  assign fe = clk_prev & ~clk_s2;

`ifdef PS2_TX_RESEND_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_cnt;
  assign last_try = (retry_cnt == RW'(MAX_RETRIES));
`else
  // MAX_RETRIES has no effect here: every failure is final.
  assign last_try = 1'b1 | (MAX_RETRIES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_prev    <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      shift       <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
      wdog        <= '0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_cnt   <= '0;
`endif
    end else begin
      clk_s1   <= ps2_clk_async;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_async;
      data_s2  <= data_s1;
      done     <= 1'b0;
      error    <= 1'b0;

      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            cnt        <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
`ifdef PS2_TX_RESEND_EN
            retry_cnt  <= '0;
`endif
          end
        end

        INHIBIT: begin
          if (cnt == PW'(INHIBIT_CYCLES - 1)) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RTS: begin
          if (cnt == PW'(RTS_CYCLES - 1)) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            wdog       <= '0;
            state      <= SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SEND: begin
          if (fe) begin
            ps2_data_oe <= ~shift[bit_idx];
            bit_idx     <= bit_idx + 1'b1;
            wdog        <= '0;
            if (bit_idx == 4'd9) state <= ACK;
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= last_try;
            state       <= FAIL;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        ACK: begin
          ps2_data_oe <= 1'b0;
          if (fe) begin
            wdog <= '0;
            if (!data_s2) begin
              state <= WAIT_IDLE;
            end else begin
              ps2_clk_oe <= 1'b0;
              error      <= last_try;
              state      <= FAIL;
            end
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            error      <= last_try;
            state      <= FAIL;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= last_try;
            state       <= FAIL;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        FAIL: begin
          // error was raised on entry so it lines up with the failing event;
          // shift is never consumed, so a retry reuses the latched frame as-is.
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RESEND_EN
          if (!last_try) begin
            retry_cnt  <= retry_cnt + 1'b1;
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end else begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
